// File: rtl/conv_layer_sequencer.sv
// Convolution layer controller: walks output positions and channel groups, issues SRAM reads
// and MAC control, and produces bank write strobes delayed by the PE pipeline latency.
module conv_layer_sequencer #(
    parameter int DIM_W    = 5,
    parameter int GRP_W    = 4,
    parameter int ADDR_W   = 6,
    parameter int WADDR_W  = 11,
    parameter int BADDR_W  = 7,
    parameter int W_WORDS  = 4,
    parameter int PIPE_LAT = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [DIM_W-1:0]   cfg_out_w,
    input  logic [DIM_W-1:0]   cfg_out_h,
    input  logic [GRP_W-1:0]   cfg_in_grp,
    input  logic [GRP_W-1:0]   cfg_out_grp,
    input  logic               cfg_src_bank,
    input  logic [WADDR_W-1:0] cfg_w_base,
    input  logic [BADDR_W-1:0] cfg_b_base,
    output logic               busy,
    output logic               layer_done,
    output logic               cfg_err,
    output logic               w_rd_en,
    output logic [WADDR_W-1:0] w_raddr,
    output logic               b_rd_en,
    output logic [BADDR_W-1:0] b_raddr,
    output logic               act_rd_en,
    output logic               act_rbank,
    output logic [ADDR_W-1:0]  act_raddr,
    output logic               mac_clear,
    output logic               mac_last,
    output logic               wen,
    output logic               wbank,
    output logic [ADDR_W-1:0]  waddr
);

    localparam int AREA_W = 2 * DIM_W;
    localparam int MUL_W  = AREA_W + GRP_W;
    localparam int WC_W   = GRP_W + $clog2(W_WORDS + 1);
    localparam int DC_W   = $clog2(PIPE_LAT + 1);

    typedef enum logic [2:0] {IDLE, LOAD_W, LOAD_B, RUN, DRAIN, DONE} state_t;

    state_t state, state_n;

    logic [DIM_W-1:0]   out_w_q, out_h_q, x_q, y_q;
    logic [GRP_W-1:0]   in_grp_q, out_grp_q, ig_q, og_q;
    logic [AREA_W-1:0]  area_q, pos_q;
    logic [BADDR_W-1:0] b_base_q;
    logic               src_q, bad_q;
    logic [WADDR_W-1:0] w_ptr;
    logic [WC_W-1:0]    wcnt_q, wtot;
    logic [DC_W-1:0]    dcnt_q;
    logic               ig_last, pos_last, og_last, wload_last, drain_last;

    logic [PIPE_LAT-1:0]             last_p;
    logic [PIPE_LAT-1:0][GRP_W-1:0]  og_p;
    logic [PIPE_LAT-1:0][AREA_W-1:0] pos_p;

    assign wtot       = WC_W'(W_WORDS) * WC_W'(in_grp_q);
    assign wload_last = (wcnt_q == wtot - WC_W'(1));
    assign ig_last    = (ig_q == in_grp_q - GRP_W'(1));
    assign og_last    = (og_q == out_grp_q - GRP_W'(1));
    assign pos_last   = (x_q == out_w_q - DIM_W'(1)) && (y_q == out_h_q - DIM_W'(1));
    assign drain_last = (dcnt_q == DC_W'(PIPE_LAT - 1));

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = LOAD_W;
            LOAD_W:  if (bad_q) state_n = DONE;
                     else if (wload_last) state_n = LOAD_B;
            LOAD_B:  state_n = RUN;
            RUN:     if (ig_last && pos_last) state_n = og_last ? DRAIN : LOAD_W;
            DRAIN:   if (drain_last) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Configuration snapshot, taken only when a start is accepted
    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            out_w_q   <= cfg_out_w;
            out_h_q   <= cfg_out_h;
            in_grp_q  <= cfg_in_grp;
            out_grp_q <= cfg_out_grp;
            b_base_q  <= cfg_b_base;
            area_q    <= AREA_W'(cfg_out_w) * AREA_W'(cfg_out_h);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            src_q  <= 1'b0;
            bad_q  <= 1'b0;
            w_ptr  <= '0;
            wcnt_q <= '0;
            dcnt_q <= '0;
            ig_q   <= '0;
            og_q   <= '0;
            x_q    <= '0;
            y_q    <= '0;
            pos_q  <= '0;
            last_p <= '0;
        end else begin
            state     <= state_n;
            last_p[0] <= mac_last;
            for (int i = 1; i < PIPE_LAT; i++) last_p[i] <= last_p[i-1];
            case (state)
                IDLE: if (start) begin
                    src_q  <= cfg_src_bank;
                    bad_q  <= (cfg_out_w == '0) || (cfg_out_h == '0) ||
                              (cfg_in_grp == '0) || (cfg_out_grp == '0);
                    w_ptr  <= cfg_w_base;
                    wcnt_q <= '0;
                    dcnt_q <= '0;
                    ig_q   <= '0;
                    og_q   <= '0;
                    x_q    <= '0;
                    y_q    <= '0;
                    pos_q  <= '0;
                end
                LOAD_W: begin
                    w_ptr  <= w_ptr + WADDR_W'(1);
                    wcnt_q <= wcnt_q + WC_W'(1);
                end
                LOAD_B: wcnt_q <= '0;
                RUN: begin
                    // ig innermost, then x, then y; the group ends on the last (pos, ig)
                    if (!ig_last) begin
                        ig_q <= ig_q + GRP_W'(1);
                    end else begin
                        ig_q <= '0;
                        if (pos_last) begin
                            x_q   <= '0;
                            y_q   <= '0;
                            pos_q <= '0;
                            if (!og_last) og_q <= og_q + GRP_W'(1);
                        end else begin
                            pos_q <= pos_q + AREA_W'(1);
                            if (x_q == out_w_q - DIM_W'(1)) begin
                                x_q <= '0;
                                y_q <= y_q + DIM_W'(1);
                            end else begin
                                x_q <= x_q + DIM_W'(1);
                            end
                        end
                    end
                end
                DRAIN: dcnt_q <= dcnt_q + DC_W'(1);
                default: ;
            endcase
        end
    end

    // Stage boundary: write address data follows mac_last through the PE latency
    always_ff @(posedge clk) begin
        og_p[0]  <= og_q;
        pos_p[0] <= pos_q;
        for (int i = 1; i < PIPE_LAT; i++) begin
            og_p[i]  <= og_p[i-1];
            pos_p[i] <= pos_p[i-1];
        end
    end

    assign busy       = (state != IDLE);
    assign layer_done = (state == DONE);
    assign cfg_err    = (state == DONE) && bad_q;
    assign w_rd_en    = (state == LOAD_W) && !bad_q;
    assign w_raddr    = w_rd_en ? w_ptr : '0;
    assign b_rd_en    = (state == LOAD_B);
    assign b_raddr    = b_rd_en ? b_base_q + BADDR_W'(og_q) : '0;
    assign act_rd_en  = (state == RUN);
    assign act_raddr  = act_rd_en ?
                        ADDR_W'(MUL_W'(ig_q) * MUL_W'(area_q) + MUL_W'(pos_q)) : '0;
    assign mac_clear  = act_rd_en && (ig_q == '0);
    assign mac_last   = act_rd_en && ig_last;
    assign act_rbank  = busy && src_q;
    assign wbank      = busy && !src_q;
    assign wen        = last_p[PIPE_LAT-1];
    assign waddr      = wen ? ADDR_W'(MUL_W'(og_p[PIPE_LAT-1]) * MUL_W'(area_q) +
                                      MUL_W'(pos_p[PIPE_LAT-1])) : '0;

endmodule

// File: doc/conv_layer_sequencer.md
Name: conv_layer_sequencer

Overview:
Parametrised layer controller that runs one convolution layer per start command over a configurable output size, input-channel group count and output-channel group count. It replaces the fixed, hard-coded per-layer CONV1/CONV2/CONV3 sequencing. The block sits between the top-level layer FSM and the SRAM/PE datapath. It issues weight, bias and activation read addresses and drives MAC control. It generates ping-pong bank write strobes delayed by the PE pipeline latency.

Parameters:
DIM_W, 5, width of the output width/height fields (max 31)
GRP_W, 4, width of the channel-group count fields
ADDR_W, 6, activation SRAM address width
WADDR_W, 11, weight SRAM address width
BADDR_W, 7, bias SRAM address width
W_WORDS, 4, weight words read per (input group, output group) pair
PIPE_LAT, 3, cycles from activation address issue to PE result valid (must be at least 1)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
start  in  1  single-cycle layer start; honoured only in IDLE
cfg_out_w  in  DIM_W  output width
cfg_out_h  in  DIM_W  output height
cfg_in_grp  in  GRP_W  input-channel groups
cfg_out_grp  in  GRP_W  output-channel groups
cfg_src_bank  in  1  0 = read group A / write B; 1 = read B / write A
cfg_w_base  in  WADDR_W  first weight address
cfg_b_base  in  BADDR_W  first bias address
busy  out  1  high in every state except IDLE
layer_done  out  1  one-cycle pulse at layer end
cfg_err  out  1  one-cycle pulse, coincident with layer_done, on an illegal config
w_rd_en  out  1  weight read strobe
w_raddr  out  WADDR_W  weight read address
b_rd_en  out  1  bias read strobe
b_raddr  out  BADDR_W  bias read address
act_rd_en  out  1  activation read strobe
act_rbank  out  1  bank being read (equals the latched cfg_src_bank)
act_raddr  out  ADDR_W  activation read address
mac_clear  out  1  first input group of a position
mac_last  out  1  last input group of a position
wen  out  1  result write strobe, active-high
wbank  out  1  bank being written (inverse of act_rbank)
waddr  out  ADDR_W  result write address

Behaviour:
- All cfg_* inputs are latched on the edge where start is accepted. Later changes to cfg_* are ignored until the next accepted start.
- start while busy is ignored.
- States and transitions:
  - IDLE -> LOAD_W on start.
  - LOAD_W: W_WORDS*in_grp cycles, w_rd_en=1. w_ptr starts at cfg_w_base and increments every LOAD_W cycle, carrying across output groups. w_raddr = w_ptr.
  - LOAD_B: 1 cycle, b_rd_en=1, b_raddr = cfg_b_base + og.
  - RUN: one cycle per (pos, ig). ig is the inner loop (0..in_grp-1). pos = y*out_w + x, with x inner and y outer.
    - act_rd_en=1.
    - act_raddr = ig*area + pos, where area = out_w*out_h, truncated to ADDR_W.
    - mac_clear = (ig==0); mac_last = (ig==in_grp-1).
  - After the last (pos, ig) of a group:
    - If og < out_grp-1: og increments, x/y/ig clear, next state is LOAD_W.
    - Otherwise next state is DRAIN.
  - DRAIN: PIPE_LAT cycles.
  - DONE: 1 cycle, layer_done=1, then IDLE.
- Write path: mac_last, og and pos pass through a PIPE_LAT-deep shift register.
  - wen = delayed mac_last.
  - waddr = og_d*area + pos_d, truncated to ADDR_W.
  - wbank is constant for the whole layer.
  - wen may still be asserting during a following LOAD_W/LOAD_B; those writes must not be dropped.
- Illegal config: any of cfg_out_w, cfg_out_h, cfg_in_grp, cfg_out_grp equal to 0.
  - Next state is DONE directly.
  - No read or write strobes are asserted.
  - cfg_err and layer_done pulse together.
- Reset, including mid-layer: next cycle is IDLE with every output 0. The write pipeline is flushed (no stale wen) and w_ptr is cleared.
- All outputs are registered or decoded from registered state. No combinational path from start to any output.

Test Plan:
- Start with out 2x2, in_grp=1, out_grp=1, w_base=0, b_base=0, PIPE_LAT=3 (start sampled at cycle 0):
  - w_rd_en at cycles 1-4 with addresses 0..3.
  - b_rd_en at cycle 5 with address 0.
  - act_raddr 0,1,2,3 at cycles 6-9.
  - wen at cycles 9-12 with waddr 0..3.
  - layer_done at cycle 13; busy high for cycles 1-13.
- Out 2x2, in_grp=2, out_grp=2, src_bank=0:
  - act_raddr sequence 0,4,1,5,2,6,3,7 per output group.
  - mac_clear on even beats, mac_last on odd beats.
  - Second group writes waddr 4..7; weight addresses 0..15 contiguous; b_raddr 0 then 1.
  - wbank=1 throughout.
- cfg_in_grp=0: layer_done and cfg_err high 2 cycles after start. w_rd_en, act_rd_en and wen never asserted.
- start re-pulsed during RUN and cfg_out_w changed mid-layer: address sequence and done timing are identical to an undisturbed run.
- rst asserted on the cycle after a mac_last in RUN: busy=0 and wen=0 the following cycle and stay 0; a subsequent start runs a clean layer with w_raddr beginning at the new cfg_w_base.
- Out 31x31, in_grp=2 (area 961 exceeds 2^ADDR_W): act_raddr and waddr wrap modulo 64. Run completes with exactly 961 wen pulses.
